fpdiv_ctrl: RTL and testbench
=============================

# fpdiv_ctrl

Control sequencer for the Goldschmidt single-precision divider datapath (`fpdiv`). It accepts a `start` pulse and drives the datapath's register enables (`en_a`, `en_b`, `en_rem`) and multiplier operand selects (`sel_mux3`, `sel_mux4`) through initial scaling, a configurable number of refinement iterations and the final remainder multiply. It then pulses `done`, after which `final_ans` on the datapath is valid. The block sits beside `fpdiv` and is the only driver of its control inputs.

## Interface
- `ITERS`, default 3: number of numerator refinement steps; legal range 1..15.
- `clk` input 1: rising-edge clock, shared with the datapath.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request a division; sampled only in IDLE.
- `abort` input 1: synchronous cancel; present only with `FPDIV_CTRL_ABORT_EN`.
- `en_a` output 1: datapath `rega` load enable (quotient estimate).
- `en_b` output 1: datapath `regb`/`regc` load enable (denominator estimate and its one's complement).
- `en_rem` output 1: datapath remainder register load enable.
- `sel_mux3` output 2: multiplier operand A select. 00 = initial approximation 0.75, 01 = `regc`, 10 = denominator.
- `sel_mux4` output 2: multiplier operand B select. 00 = numerator, 01 = denominator, 10 = `rega`, 11 = `regb`.
- `busy` output 1: a sequence is in progress.
- `done` output 1: one-cycle pulse; datapath result is valid.

## Operation
- States: IDLE, INIT_N, INIT_D, ITER_N, ITER_D, REM, DONE. Binary-encoded state register, plus iteration counter `cnt` of 4 bits.
- All outputs are Moore: decoded from the state only.
- Per-state outputs (enables not listed are 0; `busy` = 1 in every state except IDLE and DONE):
  - IDLE: sel 00/00, `busy` = 0, `done` = 0.
  - INIT_N: sel 00/00, `en_a` = 1. Captures 0.75 × N into `rega`.
  - INIT_D: sel 00/01, `en_b` = 1. Captures 0.75 × D into `regb`/`regc`.
  - ITER_N: sel 01/10, `en_a` = 1. Captures `regc` × `rega` into `rega`.
  - ITER_D: sel 01/11, `en_b` = 1. Captures `regc` × `regb` into `regb`/`regc`.
  - REM: sel 10/10, `en_rem` = 1. Captures D × Q for rounding.
  - DONE: sel 00/00, `done` = 1, `busy` = 0.
- Transitions:
  - IDLE → INIT_N when `start` = 1. `cnt` ← 0.
  - INIT_N → INIT_D → ITER_N.
  - ITER_N → REM if `cnt` == ITERS−1, else → ITER_D.
  - ITER_D → ITER_N, with `cnt` ← `cnt` + 1.
  - REM → DONE → IDLE, unconditionally.
- The final refinement updates only `rega`; the denominator is not refined after the last ITER_N.
- `start` while not in IDLE, including in DONE, is ignored and not queued.
- Datapath registers keep their contents after DONE because all enables are low. The result stays valid until the next `start`.

## Timing
- Reset (`reset` = 0) asynchronously forces:
  - state IDLE and `cnt` = 0;
  - `en_a` = `en_b` = `en_rem` = 0;
  - `sel_mux3` = `sel_mux4` = 00;
  - `busy` = 0 and `done` = 0.
- Reset is honoured in any state. A sequence interrupted by reset produces no `done`.
- `start` is sampled at edge E0. INIT_N occupies the cycle after E0.
- `busy` is high for exactly 2·ITERS + 2 cycles. `done` is high in the following cycle, for one cycle only.
  - For ITERS = 3: busy cycles 1–8, `done` in cycle 9.
- Back-to-back divisions: `start` may be held or reasserted in IDLE, the cycle after DONE. The minimum issue interval is 2·ITERS + 4 cycles.
- Each enable is asserted in exactly one state-cycle per capture. The datapath multiplier is combinational and has one full cycle to settle.

## Configuration
- `FPDIV_CTRL_ABORT_EN` defined:
  - `abort` port exists.
  - `abort` = 1 at an edge in any busy state → IDLE next cycle, with all enables low and no `done` pulse.
  - `abort` in IDLE or DONE has no effect.
  - `abort` takes priority over `start` in the same cycle.
- `FPDIV_CTRL_ABORT_EN` undefined: no `abort` port, and sequences always run to DONE.

## Test plan
- Reset sequence, ITERS = 3: hold `reset` low mid-run in ITER_D → all outputs 0 immediately. After release, IDLE; no `done`.
- ITERS = 3, single `start` pulse → per-cycle sel/enable trace is 00/00 A, 00/01 B, (01/10 A, 01/11 B)×2, 01/10 A, 10/10 R. `busy` for 8 cycles, `done` in cycle 9.
- ITERS = 1 → trace INIT_N, INIT_D, ITER_N, REM. `busy` for 4 cycles, `done` in cycle 5. ITER_D never entered.
- `start` held high continuously, ITERS = 3 → `done` every 10 cycles. `start` pulses during busy or DONE are dropped.
- With the datapath attached: 6.0 / 3.0 → `final_ans` 0x40000000. 1.0 / 3.0 → 0x3EAAAAAB after `done`.
- With `FPDIV_CTRL_ABORT_EN` defined: `abort` in cycle 4 → IDLE in cycle 5, no `done`. `en_rem` never asserted. A subsequent `start` completes normally.

Source files
------------

// File: rtl/fpdiv_ctrl_if.sv
// Control bundle between the fpdiv sequencer and its requester/datapath.
// The abort line exists only when FPDIV_CTRL_ABORT_EN is defined.
interface fpdiv_ctrl_if;
  logic       start;
`ifdef FPDIV_CTRL_ABORT_EN
  logic       abort;
`endif
  logic       en_a;
  logic       en_b;
  logic       en_rem;
  logic [1:0] sel_mux3;
  logic [1:0] sel_mux4;
  logic       busy;
  logic       done;

  // Requester side: issues start (and abort), observes the datapath controls.
  modport master (
    output start,
`ifdef FPDIV_CTRL_ABORT_EN
    output abort,
`endif
    input  en_a, en_b, en_rem, sel_mux3, sel_mux4, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start,
`ifdef FPDIV_CTRL_ABORT_EN
    input  abort,
`endif
    output en_a, en_b, en_rem, sel_mux3, sel_mux4, busy, done
  );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divider control sequencer: drives fpdiv enables and operand selects.
// Optional synchronous cancel enabled by defining FPDIV_CTRL_ABORT_EN.
module fpdiv_ctrl #(
  parameter int unsigned ITERS = 3
) (
  input logic         clk,
  input logic         reset,
  fpdiv_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StInitN, StInitD, StIterN, StIterD, StRem, StDone
  } state_e;

  localparam logic [3:0] LastCnt = 4'(ITERS - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       abort_req;

  logic       en_a_q, en_b_q, en_rem_q, busy_q, done_q;
  logic [1:0] sel_mux3_q, sel_mux4_q;

`ifdef FPDIV_CTRL_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StInitN;
          cnt_d   = '0;
        end
      end
      StInitN: state_d = StInitD;
      StInitD: state_d = StIterN;
      // The last refinement skips ITER_D: the denominator is not needed again.
      StIterN: state_d = (cnt_q == LastCnt) ? StRem : StIterD;
      StIterD: begin
        state_d = StIterN;
        cnt_d   = cnt_q + 4'd1;
      end
      StRem:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_req && state_q != StIdle && state_q != StDone) begin
      state_d = StIdle;
    end
  end

  // Outputs are registered from the next state, so they are a pure function of state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      en_a_q     <= 1'b0;
      en_b_q     <= 1'b0;
      en_rem_q   <= 1'b0;
      sel_mux3_q <= 2'b00;
      sel_mux4_q <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_a_q     <= (state_d == StInitN) || (state_d == StIterN);
      en_b_q     <= (state_d == StInitD) || (state_d == StIterD);
      en_rem_q   <= (state_d == StRem);
      busy_q     <= (state_d != StIdle) && (state_d != StDone);
      done_q     <= (state_d == StDone);
      case (state_d)
        StInitD: begin
          sel_mux3_q <= 2'b00;
          sel_mux4_q <= 2'b01;
        end
        StIterN: begin
          sel_mux3_q <= 2'b01;
          sel_mux4_q <= 2'b10;
        end
        StIterD: begin
          sel_mux3_q <= 2'b01;
          sel_mux4_q <= 2'b11;
        end
        StRem: begin
          sel_mux3_q <= 2'b10;
          sel_mux4_q <= 2'b10;
        end
        default: begin
          sel_mux3_q <= 2'b00;
          sel_mux4_q <= 2'b00;
        end
      endcase
    end
  end

  assign bus.en_a     = en_a_q;
  assign bus.en_b     = en_b_q;
  assign bus.en_rem   = en_rem_q;
  assign bus.sel_mux3 = sel_mux3_q;
  assign bus.sel_mux4 = sel_mux4_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed table-driven bench for fpdiv_ctrl with ITERS = 3 and ITERS = 1 instances.
module tb_fpdiv_ctrl;

  // Output vector layout: {sel_mux3, sel_mux4, en_a, en_b, en_rem, busy, done}
  localparam logic [8:0] V_IDLE  = {2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [8:0] V_INITN = {2'b00, 2'b00, 3'b100, 2'b10};
  localparam logic [8:0] V_INITD = {2'b00, 2'b01, 3'b010, 2'b10};
  localparam logic [8:0] V_ITERN = {2'b01, 2'b10, 3'b100, 2'b10};
  localparam logic [8:0] V_ITERD = {2'b01, 2'b11, 3'b010, 2'b10};
  localparam logic [8:0] V_REM   = {2'b10, 2'b10, 3'b001, 2'b10};
  localparam logic [8:0] V_DONE  = {2'b00, 2'b00, 3'b000, 2'b01};

  typedef struct {
    logic       start;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpdiv_ctrl_if if3 ();
  fpdiv_ctrl_if if1 ();

  fpdiv_ctrl #(.ITERS(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));
  fpdiv_ctrl #(.ITERS(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  logic [8:0] act3, act1;
  assign act3 = {if3.sel_mux3, if3.sel_mux4, if3.en_a, if3.en_b, if3.en_rem, if3.busy, if3.done};
  assign act1 = {if1.sel_mux3, if1.sel_mux4, if1.en_a, if1.en_b, if1.en_rem, if1.busy, if1.done};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [8:0] got,
                       input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, got, exp);
    end
  endtask

  vec_t tr3[12];
  vec_t tr1[6];
  logic [8:0] per3[10];

  initial begin
    // ITERS=3 trace; start pulses while busy (i=3) and in DONE (i=9) must be dropped.
    tr3[0]  = '{1'b1, V_INITN};
    tr3[1]  = '{1'b0, V_INITD};
    tr3[2]  = '{1'b0, V_ITERN};
    tr3[3]  = '{1'b1, V_ITERD};
    tr3[4]  = '{1'b0, V_ITERN};
    tr3[5]  = '{1'b0, V_ITERD};
    tr3[6]  = '{1'b0, V_ITERN};
    tr3[7]  = '{1'b0, V_REM};
    tr3[8]  = '{1'b0, V_DONE};
    tr3[9]  = '{1'b1, V_IDLE};
    tr3[10] = '{1'b0, V_IDLE};
    tr3[11] = '{1'b0, V_IDLE};

    tr1[0] = '{1'b1, V_INITN};
    tr1[1] = '{1'b0, V_INITD};
    tr1[2] = '{1'b0, V_ITERN};
    tr1[3] = '{1'b0, V_REM};
    tr1[4] = '{1'b0, V_DONE};
    tr1[5] = '{1'b0, V_IDLE};

    per3[0] = V_IDLE;
    for (int i = 1; i < 10; i++) per3[i] = tr3[i-1].exp;

    reset     = 1'b0;
    if3.start = 1'b0;
    if1.start = 1'b0;
`ifdef FPDIV_CTRL_ABORT_EN
    if3.abort = 1'b0;
    if1.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_state3", 0, act3, V_IDLE);
    check("reset_state1", 0, act1, V_IDLE);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 0, act3, V_IDLE);

    // Single pulse, ITERS=3, with dropped start pulses.
    for (int i = 0; i < 12; i++) begin
      if3.start = tr3[i].start;
      @(negedge clk);
      check("trace3", i + 1, act3, tr3[i].exp);
    end
    if3.start = 1'b0;

    // ITERS=1: ITER_D never entered.
    for (int i = 0; i < 6; i++) begin
      if1.start = tr1[i].start;
      @(negedge clk);
      check("trace1", i + 1, act1, tr1[i].exp);
      check("iters3_quiet", i + 1, act3, V_IDLE);
    end
    if1.start = 1'b0;

    // start held high: one done every 10 cycles.
    if3.start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("held_start", k, act3, per3[k % 10]);
    end
    if3.start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("held_release", 0, act3, V_IDLE);
    end

    // Asynchronous reset in ITER_D.
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_iterd", 4, act3, V_ITERD);
    reset = 1'b0;
    #1;
    check("reset_async", 0, act3, V_IDLE);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("post_reset_idle", k, act3, V_IDLE);
    end

`ifdef FPDIV_CTRL_ABORT_EN
    // Abort sampled at the end of cycle 4 -> IDLE in cycle 5, no REM and no done.
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_iterd", 4, act3, V_ITERD);
    if3.abort = 1'b1;
    @(negedge clk);
    if3.abort = 1'b0;
    check("abort_idle", 5, act3, V_IDLE);
    for (int k = 6; k < 14; k++) begin
      @(negedge clk);
      check("post_abort_idle", k, act3, V_IDLE);
    end
    // abort in IDLE has no effect and loses to nothing; a new division completes.
    for (int i = 0; i < 12; i++) begin
      if3.start = tr3[i].start;
      if3.abort = (i == 10);
      @(negedge clk);
      check("after_abort_trace", i + 1, act3, tr3[i].exp);
    end
    if3.start = 1'b0;
    if3.abort = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
